// File: rtl/vm1_irq_sched_pkg.sv
// Shared definitions for the VM1 interrupt/exception scheduler:
// source indices, vector table, masking sets and FSM encoding.
package vm1_irq_sched_pkg;

    localparam int NUM_SRC = 9;

    localparam logic [3:0] SRC_NONE = 4'd0;
    localparam logic [3:0] SRC_QBTO = 4'd1;
    localparam logic [3:0] SRC_IATO = 4'd2;
    localparam logic [3:0] SRC_UERR = 4'd3;
    localparam logic [3:0] SRC_TBIT = 4'd4;
    localparam logic [3:0] SRC_ACLO = 4'd5;
    localparam logic [3:0] SRC_IRQ1 = 4'd6;
    localparam logic [3:0] SRC_IRQ2 = 4'd7;
    localparam logic [3:0] SRC_IRQ3 = 4'd8;
    localparam logic [3:0] SRC_VIRQ = 4'd9;

    localparam logic [15:0] VEC_QBTO = 16'o000004;
    localparam logic [15:0] VEC_IATO = 16'o000004;
    localparam logic [15:0] VEC_UERR = 16'o000010;
    localparam logic [15:0] VEC_TBIT = 16'o000014;
    localparam logic [15:0] VEC_ACLO = 16'o000024;
    localparam logic [15:0] VEC_IRQ1 = 16'o160002;
    localparam logic [15:0] VEC_IRQ2 = 16'o000100;
    localparam logic [15:0] VEC_IRQ3 = 16'o000270;

    // Bit n of a source vector corresponds to source index n+1.
    // Halt mode blocks aclo, irq1..irq3 and virq; psw7 blocks irq2, irq3, virq.
    localparam logic [NUM_SRC-1:0] HALT_MASK = 9'b1_1111_0000;
    localparam logic [NUM_SRC-1:0] PRIO_MASK = 9'b1_1100_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CLEAR   = 2'd2
    } schedState_t;

    // Vector lookup; the vectored interrupt takes the externally supplied vector.
    function automatic logic [15:0] srcVector(input logic [3:0] src, input logic [15:0] extVec);
        logic [15:0] v;
        case (src)
            SRC_QBTO: v = VEC_QBTO;
            SRC_IATO: v = VEC_IATO;
            SRC_UERR: v = VEC_UERR;
            SRC_TBIT: v = VEC_TBIT;
            SRC_ACLO: v = VEC_ACLO;
            SRC_IRQ1: v = VEC_IRQ1;
            SRC_IRQ2: v = VEC_IRQ2;
            SRC_IRQ3: v = VEC_IRQ3;
            SRC_VIRQ: v = extVec;
            default:  v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm1_irq_sched_prio.sv
// Fixed-priority encoder: returns the index (1 = highest) of the first
// pending source, or 0 when nothing is pending.
module vm1_irq_prio
    import vm1_irq_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_pending,
    output logic [3:0]         o_index
);

    // Scan from lowest to highest priority so the highest pending source wins.
    always_comb begin
        o_index = SRC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_index = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/vm1_irq_sched.sv
// VM1 interrupt/exception scheduler: collects exception and interrupt
// sources, arbitrates by fixed priority and presents one request at a time
// to the microsequencer with an ack handshake and a one-cycle clear gap.
module vm1_irq_sched
    import vm1_irq_sched_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_init,
    input  logic        i_qbto,
    input  logic        i_iato,
    input  logic        i_uerr,
    input  logic        i_aclo,
    input  logic        i_irq1,
    input  logic        i_irq2,
    input  logic        i_irq3,
    input  logic        i_virq,
    input  logic [15:0] i_extVec,
    input  logic        i_tbit,
    input  logic        i_psw7,
    input  logic        i_psw10,
    input  logic        i_wcpu,
    input  logic        i_ack,
    output logic        o_req,
    output logic [3:0]  o_code,
    output logic [15:0] o_vec,
    output logic        o_wake
);

    schedState_t        r_state;
    schedState_t        w_nextState;

    logic [2:0]         r_excFlags;
    logic [3:0]         r_edgeFlags;
    logic [3:0]         r_edgePrev;
    logic               r_reload;
    logic [3:0]         r_code;
    logic [15:0]        r_vec;
    logic               r_wake;

    logic [2:0]         w_excIn;
    logic [2:0]         w_excClr;
    logic [3:0]         w_edgeIn;
    logic [3:0]         w_edgeRise;
    logic [3:0]         w_edgeClr;
    logic [NUM_SRC-1:0] w_raw;
    logic [NUM_SRC-1:0] w_haltMask;
    logic [NUM_SRC-1:0] w_prioMask;
    logic [NUM_SRC-1:0] w_pending;
    logic [3:0]         w_winner;
    logic               w_ackTaken;
    logic               w_grant;

    assign w_excIn    = {i_uerr, i_iato, i_qbto};
    assign w_edgeIn   = {i_irq3, i_irq2, i_irq1, i_aclo};
    // The first cycle after init only reloads history, so held levels never arm.
    assign w_edgeRise = w_edgeIn & ~r_edgePrev & {4{~r_reload}};

    assign w_ackTaken = (r_state == ST_PRESENT) && i_ack;
    assign w_grant    = (r_state == ST_IDLE) && (w_winner != SRC_NONE);

    // Pending vector ordered by source index; tbit and virq are live levels.
    assign w_raw      = {i_virq, r_edgeFlags, i_tbit, r_excFlags};
    assign w_haltMask = i_psw10 ? HALT_MASK : '0;
    assign w_prioMask = i_psw7  ? PRIO_MASK : '0;
    assign w_pending  = w_raw & ~(w_haltMask | w_prioMask);

    vm1_irq_prio u_prio (
        .i_pending (w_pending),
        .o_index   (w_winner)
    );

    // Decode which stored flag the accepted request retires.
    always_comb begin
        w_excClr  = '0;
        w_edgeClr = '0;
        for (int i = 0; i < 3; i++) begin
            w_excClr[i] = w_ackTaken && (r_code == 4'(SRC_QBTO + 4'(i)));
        end
        for (int i = 0; i < 4; i++) begin
            w_edgeClr[i] = w_ackTaken && (r_code == 4'(SRC_ACLO + 4'(i)));
        end
    end

    // Source flags and edge history; a new set beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_excFlags  <= '0;
            r_edgeFlags <= '0;
            r_edgePrev  <= '0;
            r_reload    <= 1'b1;
        end else begin
            r_excFlags  <= (r_excFlags & ~w_excClr) | w_excIn;
            r_edgeFlags <= (r_edgeFlags & ~w_edgeClr) | w_edgeRise;
            r_edgePrev  <= w_edgeIn;
            r_reload    <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold until ack, one clear cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_nextState = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_ack) begin
                    w_nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Freeze the winner's index and vector on the grant edge.
    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_code <= SRC_NONE;
            r_vec  <= '0;
        end else if (w_grant) begin
            r_code <= w_winner;
            r_vec  <= srcVector(w_winner, i_extVec);
        end
    end

    // WAIT wakeup ignores the psw7 priority mask but honours halt mode.
    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_wake <= 1'b0;
        end else begin
            r_wake <= i_wcpu && (|(w_raw & ~w_haltMask));
        end
    end

    // Outputs are only live while a request is presented.
    always_comb begin
        o_req  = 1'b0;
        o_code = SRC_NONE;
        o_vec  = '0;
        if (r_state == ST_PRESENT) begin
            o_req  = 1'b1;
            o_code = r_code;
            o_vec  = r_vec;
        end
        o_wake = r_wake;
    end

endmodule

// File: tb/tb_vm1_irq_sched.sv
// Self-checking bench for vm1_irq_sched: directed scenarios with fixed
// expectations plus a randomized run compared against a behavioural model.
module tb_vm1_irq_sched;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        qbto = 1'b0, iato = 1'b0, uerr = 1'b0;
    logic        aclo = 1'b0, irq1 = 1'b0, irq2 = 1'b0, irq3 = 1'b0;
    logic        virq = 1'b0;
    logic [15:0] extVec = '0;
    logic        tbit = 1'b0, psw7 = 1'b0, psw10 = 1'b0, wcpu = 1'b0, ack = 1'b0;
    logic        req;
    logic [3:0]  code;
    logic [15:0] vec;
    logic        wake;

    int passCount = 0;
    int checkCount = 0;

    vm1_irq_sched dut (
        .i_clk    (clk),
        .i_init   (init),
        .i_qbto   (qbto),
        .i_iato   (iato),
        .i_uerr   (uerr),
        .i_aclo   (aclo),
        .i_irq1   (irq1),
        .i_irq2   (irq2),
        .i_irq3   (irq3),
        .i_virq   (virq),
        .i_extVec (extVec),
        .i_tbit   (tbit),
        .i_psw7   (psw7),
        .i_psw10  (psw10),
        .i_wcpu   (wcpu),
        .i_ack    (ack),
        .o_req    (req),
        .o_code   (code),
        .o_vec    (vec),
        .o_wake   (wake)
    );

    always #5 clk = ~clk;

    // Reference model: per-source armed bits indexed by source number,
    // presentation phase 0 = idle, 1 = presenting, 2 = clearing.
    typedef struct packed {
        logic [9:1]  armed;
        logic [9:1]  prevLvl;
        logic        histStale;
        logic [1:0]  phase;
        logic [3:0]  code;
        logic [15:0] vec;
        logic        wake;
    } model_t;

    model_t mState = '0;

    function automatic logic [15:0] vecTable(int s, logic [15:0] ev);
        case (s)
            1, 2:    return 16'o000004;
            3:       return 16'o000010;
            4:       return 16'o000014;
            5:       return 16'o000024;
            6:       return 16'o160002;
            7:       return 16'o000100;
            8:       return 16'o000270;
            9:       return ev;
            default: return 16'd0;
        endcase
    endfunction

    function automatic model_t modelNext(model_t m, logic rst, logic [9:1] lvl, logic p7,
                                         logic p10, logic wc, logic ak, logic [15:0] ev);
        model_t n;
        int     clearSrc;
        int     pick;
        logic   anyWake;
        logic   pend;
        n = m;
        if (rst) begin
            n = '0;
            n.histStale = 1'b1;
            return n;
        end
        clearSrc = 0;
        pick = 0;
        anyWake = 1'b0;
        for (int s = 9; s >= 1; s--) begin
            pend = (s == 4 || s == 9) ? lvl[s] : m.armed[s];
            if (pend && !(p10 && s >= 5)) anyWake = 1'b1;
            if (pend && !(p10 && s >= 5) && !(p7 && s >= 7)) pick = s;
        end
        n.wake = wc && anyWake;
        case (m.phase)
            2'd0: begin
                if (pick != 0) begin
                    n.phase = 2'd1;
                    n.code = 4'(pick);
                    n.vec = vecTable(pick, ev);
                end
            end
            2'd1: begin
                if (ak) begin
                    n.phase = 2'd2;
                    clearSrc = int'(m.code);
                end
            end
            default: n.phase = 2'd0;
        endcase
        for (int s = 1; s <= 9; s++) begin
            if (s >= 1 && s <= 3)
                n.armed[s] = (m.armed[s] && s != clearSrc) || lvl[s];
            else if (s >= 5 && s <= 8)
                n.armed[s] = (m.armed[s] && s != clearSrc) ||
                             (lvl[s] && !m.prevLvl[s] && !m.histStale);
            else
                n.armed[s] = 1'b0;
        end
        n.prevLvl = lvl;
        n.histStale = 1'b0;
        return n;
    endfunction

    always @(posedge clk) begin
        mState <= modelNext(mState, init, {virq, irq3, irq2, irq1, aclo, tbit, uerr, iato, qbto},
                            psw7, psw10, wcpu, ack, extVec);
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        qbto = 0; iato = 0; uerr = 0; aclo = 0; irq1 = 0; irq2 = 0; irq3 = 0;
        virq = 0; extVec = '0; tbit = 0; psw7 = 0; psw10 = 0; wcpu = 0; ack = 0;
    endtask

    task automatic doReset();
        clearInputs();
        init = 1;
        cycle();
        init = 0;
        cycle();
    endtask

    task automatic test_reset();
        clearInputs();
        init = 1;
        cycle();
        cycle();
        checkCount++;
        if (req !== 1'b0) $display("[TB] FAIL reset_req got %0b want 0", req); else passCount++;
        checkCount++;
        if (code !== 4'd0) $display("[TB] FAIL reset_code got %0d want 0", code); else passCount++;
        checkCount++;
        if (vec !== 16'd0) $display("[TB] FAIL reset_vec got %o want 0", vec); else passCount++;
        checkCount++;
        if (wake !== 1'b0) $display("[TB] FAIL reset_wake got %0b want 0", wake); else passCount++;
        init = 0;
        cycle();
    endtask

    task automatic test_uerr_pulse();
        doReset();
        uerr = 1;
        cycle();
        uerr = 0;
        checkCount++;
        if (req !== 1'b0) $display("[TB] FAIL uerr_early got %0b want 0", req); else passCount++;
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd3 || vec !== 16'o000010)
            $display("[TB] FAIL uerr_present got req=%0b code=%0d vec=%o want 1/3/10", req, code, vec);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        checkCount++;
        if (req !== 1'b0 || code !== 4'd0)
            $display("[TB] FAIL uerr_clear got req=%0b code=%0d want 0/0", req, code);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkCount++;
            if (req !== 1'b0) $display("[TB] FAIL uerr_quiet got %0b want 0", req); else passCount++;
        end
    endtask

    task automatic test_same_edge();
        logic got;
        doReset();
        irq2 = 1;
        irq3 = 1;
        cycle();
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd7 || vec !== 16'o000100)
            $display("[TB] FAIL same_edge_first got req=%0b code=%0d vec=%o want 1/7/100", req, code, vec);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        checkCount++;
        if (req !== 1'b0 || code !== 4'd0)
            $display("[TB] FAIL same_edge_gap got req=%0b code=%0d want 0/0", req, code);
        else passCount++;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            cycle();
            if (req) got = 1;
        end
        checkCount++;
        if (!got || code !== 4'd8 || vec !== 16'o000270)
            $display("[TB] FAIL same_edge_second got req=%0b code=%0d vec=%o want 1/8/270", req, code, vec);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        irq2 = 0;
        irq3 = 0;
    endtask

    task automatic test_virq_mask();
        doReset();
        psw7 = 1;
        virq = 1;
        extVec = 16'o000300;
        cycle();
        cycle();
        cycle();
        checkCount++;
        if (req !== 1'b0) $display("[TB] FAIL virq_masked got %0b want 0", req); else passCount++;
        psw7 = 0;
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd9 || vec !== 16'o000300)
            $display("[TB] FAIL virq_present got req=%0b code=%0d vec=%o want 1/9/300", req, code, vec);
        else passCount++;
        extVec = 16'o000777;
        virq = 0;
        psw7 = 1;
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd9 || vec !== 16'o000300)
            $display("[TB] FAIL virq_hold got req=%0b code=%0d vec=%o want 1/9/300", req, code, vec);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        psw7 = 0;
    endtask

    task automatic test_wake();
        doReset();
        wcpu = 1;
        psw7 = 1;
        irq3 = 1;
        cycle();
        cycle();
        checkCount++;
        if (wake !== 1'b1 || req !== 1'b0)
            $display("[TB] FAIL wake_masked got wake=%0b req=%0b want 1/0", wake, req);
        else passCount++;
        psw7 = 0;
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd8)
            $display("[TB] FAIL wake_present got req=%0b code=%0d want 1/8", req, code);
        else passCount++;
        ack = 1;
        wcpu = 0;
        cycle();
        ack = 0;
        irq3 = 0;
        cycle();
        checkCount++;
        if (wake !== 1'b0) $display("[TB] FAIL wake_drop got %0b want 0", wake); else passCount++;
    endtask

    task automatic test_no_preempt();
        logic got;
        doReset();
        aclo = 1;
        cycle();
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd5 || vec !== 16'o000024)
            $display("[TB] FAIL aclo_present got req=%0b code=%0d vec=%o want 1/5/24", req, code, vec);
        else passCount++;
        qbto = 1;
        cycle();
        qbto = 0;
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd5)
            $display("[TB] FAIL no_preempt got req=%0b code=%0d want 1/5", req, code);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            cycle();
            if (req) got = 1;
        end
        checkCount++;
        if (!got || code !== 4'd1 || vec !== 16'o000004)
            $display("[TB] FAIL qbto_after got req=%0b code=%0d vec=%o want 1/1/4", req, code, vec);
        else passCount++;
        ack = 1;
        cycle();
        ack = 0;
        aclo = 0;
    endtask

    task automatic test_init_mid_present();
        doReset();
        irq1 = 1;
        cycle();
        cycle();
        checkCount++;
        if (req !== 1'b1 || code !== 4'd6 || vec !== 16'o160002)
            $display("[TB] FAIL irq1_present got req=%0b code=%0d vec=%o want 1/6/160002", req, code, vec);
        else passCount++;
        init = 1;
        cycle();
        checkCount++;
        if (req !== 1'b0 || code !== 4'd0 || vec !== 16'd0 || wake !== 1'b0)
            $display("[TB] FAIL init_abandon got req=%0b code=%0d vec=%o wake=%0b want all 0", req, code, vec, wake);
        else passCount++;
        init = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkCount++;
            if (req !== 1'b0) $display("[TB] FAIL irq1_held_level got %0b want 0", req); else passCount++;
        end
        irq1 = 0;
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            init   = ($urandom_range(0, 99) == 0);
            qbto   = ($urandom_range(0, 19) == 0);
            iato   = ($urandom_range(0, 19) == 0);
            uerr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) aclo = ~aclo;
            if ($urandom_range(0, 7) == 0) irq1 = ~irq1;
            if ($urandom_range(0, 7) == 0) irq2 = ~irq2;
            if ($urandom_range(0, 7) == 0) irq3 = ~irq3;
            if ($urandom_range(0, 9) == 0) virq = ~virq;
            if ($urandom_range(0, 11) == 0) tbit = ~tbit;
            if ($urandom_range(0, 11) == 0) psw7 = ~psw7;
            if ($urandom_range(0, 15) == 0) psw10 = ~psw10;
            wcpu   = ($urandom_range(0, 3) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            extVec = 16'($urandom);
            cycle();
            checkCount++;
            if (req !== (mState.phase == 2'd1))
                $display("[TB] FAIL rand_req cyc=%0d got %0b want %0b", c, req, (mState.phase == 2'd1));
            else passCount++;
            checkCount++;
            if (code !== ((mState.phase == 2'd1) ? mState.code : 4'd0))
                $display("[TB] FAIL rand_code cyc=%0d got %0d want %0d", c, code,
                         ((mState.phase == 2'd1) ? mState.code : 4'd0));
            else passCount++;
            checkCount++;
            if (vec !== ((mState.phase == 2'd1) ? mState.vec : 16'd0))
                $display("[TB] FAIL rand_vec cyc=%0d got %o want %o", c, vec,
                         ((mState.phase == 2'd1) ? mState.vec : 16'd0));
            else passCount++;
            checkCount++;
            if (wake !== mState.wake)
                $display("[TB] FAIL rand_wake cyc=%0d got %0b want %0b", c, wake, mState.wake);
            else passCount++;
        end
        clearInputs();
        init = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_uerr_pulse();
        test_same_edge();
        test_virq_mask();
        test_wake();
        test_no_preempt();
        test_init_mid_present();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
